// File: rtl/cascaded_counter.sv
// Chain of STAGES up-counters with per-stage limits, sequential or odometer cascade.
// Optional synchronous load path compiled in with CASCADED_COUNTER_LOAD_EN.
module cascaded_counter #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      clear_i,
    input  logic                      mode_i,
    input  logic [STAGES*WIDTH-1:0]   limits_i,
`ifdef CASCADED_COUNTER_LOAD_EN
    input  logic                      load_i,
    input  logic [STAGES*WIDTH-1:0]   load_value_i,
`endif
    output logic [STAGES*WIDTH-1:0]   count_o,
    output logic                      done_o,
    output logic                      wrap_o
);

    logic [STAGES-1:0][WIDTH-1:0] count_p0;
    logic [STAGES-1:0][WIDTH-1:0] limit;
    logic [STAGES-1:0][WIDTH-1:0] next_value;
    logic [STAGES-1:0]            full;
    logic                         all_full;
    logic                         found;
    logic                         carry;
    logic                         wrap_p0;

    // Stage 0 lives in the most-significant slice of the packed buses.
    always_comb begin
        limit   = '0;
        full    = '0;
        count_o = '0;
        for (int k = 0; k < STAGES; k++) begin
            limit[k] = limits_i[(STAGES-1-k)*WIDTH +: WIDTH];
            full[k]  = count_p0[k] >= limit[k];
            count_o[(STAGES-1-k)*WIDTH +: WIDTH] = count_p0[k];
        end
    end

    assign all_full = &full;
    assign done_o   = all_full;
    assign wrap_o   = wrap_p0;

    // A full stage never increments, so the +1 cannot overflow.
    always_comb begin
        next_value = count_p0;
        found      = 1'b0;
        carry      = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            if (mode_i) begin
                if (carry)
                    next_value[k] = full[k] ? '0 : count_p0[k] + WIDTH'(1);
                carry = carry & full[k];
            end else if (!all_full && !found && !full[k]) begin
                next_value[k] = count_p0[k] + WIDTH'(1);
                found         = 1'b1;
            end
        end
        if (!mode_i && all_full)
            next_value = '0;
    end

`ifdef CASCADED_COUNTER_LOAD_EN
    logic [STAGES-1:0][WIDTH-1:0] load_value;

    always_comb begin
        load_value = '0;
        for (int k = 0; k < STAGES; k++)
            load_value[k] = load_value_i[(STAGES-1-k)*WIDTH +: WIDTH];
    end
`endif

    // p0: counter state and wrap pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_p0 <= '0;
            wrap_p0  <= 1'b0;
        end else if (clear_i) begin
            count_p0 <= '0;
            wrap_p0  <= 1'b0;
`ifdef CASCADED_COUNTER_LOAD_EN
        end else if (load_i) begin
            count_p0 <= load_value;
            wrap_p0  <= 1'b0;
`endif
        end else if (en_i) begin
            count_p0 <= next_value;
            wrap_p0  <= all_full;
        end else begin
            wrap_p0  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cascaded_counter.sv
// Scoreboard bench for cascaded_counter: a 2-stage and a 3-stage instance share clock and reset.
module tb_cascaded_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, clear, mode, en_b;
    logic [15:0] limits_a;
    logic [23:0] limits_b;
    logic [15:0] count_a;
    logic [23:0] count_b;
    logic        done_a, wrap_a, done_b, wrap_b;
`ifdef CASCADED_COUNTER_LOAD_EN
    logic        load;
    logic [15:0] load_value;
`endif

    int checks = 0;
    int fails  = 0;
    logic [26:0] exp_q[$];
    string       name_q[$];
    event        chk_now;

    always #5 clk = ~clk;

    cascaded_counter #(.WIDTH(8), .STAGES(2)) dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .clear_i      (clear),
        .mode_i       (mode),
        .limits_i     (limits_a),
`ifdef CASCADED_COUNTER_LOAD_EN
        .load_i       (load),
        .load_value_i (load_value),
`endif
        .count_o      (count_a),
        .done_o       (done_a),
        .wrap_o       (wrap_a)
    );

    cascaded_counter #(.WIDTH(8), .STAGES(3)) dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en_b),
        .clear_i      (1'b0),
        .mode_i       (1'b0),
        .limits_i     (limits_b),
`ifdef CASCADED_COUNTER_LOAD_EN
        .load_i       (1'b0),
        .load_value_i (24'h0),
`endif
        .count_o      (count_b),
        .done_o       (done_b),
        .wrap_o       (wrap_b)
    );

    // Expected entry layout: {select_b, count[23:0], done, wrap}
    function automatic void push_a(string nm, logic [7:0] s0, logic [7:0] s1, logic d, logic w);
        exp_q.push_back({1'b0, 8'h00, s0, s1, d, w});
        name_q.push_back(nm);
    endfunction

    function automatic void push_b(string nm, logic [7:0] s0, logic [7:0] s1, logic [7:0] s2,
                                   logic d, logic w);
        exp_q.push_back({1'b1, s0, s1, s2, d, w});
        name_q.push_back(nm);
    endfunction

    task automatic tick_a(string nm, logic [7:0] s0, logic [7:0] s1, logic d, logic w);
        @(posedge clk);
        #1;
        push_a(nm, s0, s1, d, w);
    endtask

    task automatic tick_b(string nm, logic [7:0] s0, logic [7:0] s1, logic [7:0] s2,
                          logic d, logic w);
        @(posedge clk);
        #1;
        push_b(nm, s0, s1, s2, d, w);
    endtask

    initial begin : monitor
        logic [26:0] e, act;
        string       nm;
        forever begin
            @(negedge clk or chk_now);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = e[26] ? {1'b1, count_b, done_b, wrap_b}
                            : {1'b0, 8'h00, count_a, done_a, wrap_a};
                checks++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL %s: got count=%h done=%b wrap=%b, expected count=%h done=%b wrap=%b",
                             nm, act[25:2], act[1], act[0], e[25:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: stimulus did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst      = 1'b1;
        en       = 1'b1;
        clear    = 1'b0;
        mode     = 1'b0;
        en_b     = 1'b0;
        limits_a = {8'd8, 8'd6};
        limits_b = {8'd2, 8'd0, 8'd1};
`ifdef CASCADED_COUNTER_LOAD_EN
        load       = 1'b0;
        load_value = 16'h0;
`endif
        @(posedge clk);
        #1;
        push_a("reset_a", 8'd0, 8'd0, 1'b0, 1'b0);
        push_b("reset_b", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (count_a !== 16'h0000) begin
            fails++;
            $display("FAIL reset_direct: count_a=%h expected 0000", count_a);
        end
        @(negedge clk);
        rst = 1'b0;

        // Sequential baseline {8,6}
        for (int i = 1; i <= 8; i++) tick_a("seq_s0", 8'(i), 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) tick_a("seq_s1", 8'd8, 8'(i), i == 6, 1'b0);
        tick_a("seq_wrap", 8'd0, 8'd0, 1'b0, 1'b1);
        checks++;
        if (wrap_a !== 1'b1) begin
            fails++;
            $display("FAIL seq_wrap_direct: wrap_a=%b expected 1", wrap_a);
        end
        en = 1'b0;
        tick_a("wrap_fall", 8'd0, 8'd0, 1'b0, 1'b0);
        en = 1'b1;

        // Hold at {3,0}, with a limit change while disabled
        for (int i = 1; i <= 3; i++) tick_a("count3", 8'(i), 8'd0, 1'b0, 1'b0);
        en = 1'b0;
        tick_a("hold", 8'd3, 8'd0, 1'b0, 1'b0);
        tick_a("hold", 8'd3, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1 limits_a = {8'd2, 8'd0};
        tick_a("hold_limit", 8'd3, 8'd0, 1'b1, 1'b0);
        @(negedge clk);
        #1 limits_a = {8'd8, 8'd6};
        tick_a("hold", 8'd3, 8'd0, 1'b0, 1'b0);
        tick_a("hold", 8'd3, 8'd0, 1'b0, 1'b0);
        en = 1'b1;

        // Clear while all full and enabled: no wrap
        for (int i = 4; i <= 8; i++) tick_a("seq_s0b", 8'(i), 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) tick_a("seq_s1b", 8'd8, 8'(i), i == 6, 1'b0);
        clear = 1'b1;
        tick_a("clear", 8'd0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (wrap_a !== 1'b0) begin
            fails++;
            $display("FAIL clear_direct: wrap_a=%b expected 0", wrap_a);
        end
        clear = 1'b0;

        // Async reset between edges at {8,4}
        for (int i = 1; i <= 8; i++) tick_a("pre_rst_s0", 8'(i), 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) tick_a("pre_rst_s1", 8'd8, 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1 push_a("async_rst", 8'd0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (count_a !== 16'h0000) begin
            fails++;
            $display("FAIL async_rst_direct: count_a=%h expected 0000", count_a);
        end
        -> chk_now;

        // Lower L0 from 8 to 3 while stage 0 = 5
        for (int i = 1; i <= 5; i++) tick_a("after_rst", 8'(i), 8'd0, 1'b0, 1'b0);
        limits_a = {8'd3, 8'd6};
        for (int i = 1; i <= 6; i++) tick_a("low_limit", 8'd5, 8'(i), i == 6, 1'b0);
        tick_a("low_wrap", 8'd0, 8'd0, 1'b0, 1'b1);

        // Odometer {2,3}: period 12
        limits_a = {8'd2, 8'd3};
        mode     = 1'b1;
        clear    = 1'b1;
        tick_a("odo_clear", 8'd0, 8'd0, 1'b0, 1'b0);
        clear = 1'b0;
        for (int i = 1; i <= 11; i++) tick_a("odo", 8'(i % 3), 8'(i / 3), i == 11, 1'b0);
        tick_a("odo_wrap", 8'd0, 8'd0, 1'b0, 1'b1);
        en   = 1'b0;
        en_b = 1'b1;

        // Three stages {2,0,1}: middle stage skipped, period 4
        tick_b("skip", 8'd1, 8'd0, 8'd0, 1'b0, 1'b0);
        tick_b("skip", 8'd2, 8'd0, 8'd0, 1'b0, 1'b0);
        tick_b("skip_full", 8'd2, 8'd0, 8'd1, 1'b1, 1'b0);
        tick_b("skip_wrap", 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        checks++;
        if (wrap_b !== 1'b1) begin
            fails++;
            $display("FAIL skip_wrap_direct: wrap_b=%b expected 1", wrap_b);
        end
        tick_b("skip_next", 8'd1, 8'd0, 8'd0, 1'b0, 1'b0);
        en_b = 1'b0;

`ifdef CASCADED_COUNTER_LOAD_EN
        // Load {7,5} while disabled, then count through wrap
        mode       = 1'b0;
        limits_a   = {8'd8, 8'd6};
        load       = 1'b1;
        load_value = {8'd7, 8'd5};
        tick_a("load", 8'd7, 8'd5, 1'b0, 1'b0);
        load = 1'b0;
        en   = 1'b1;
        tick_a("load_s0", 8'd8, 8'd5, 1'b0, 1'b0);
        tick_a("load_s1", 8'd8, 8'd6, 1'b1, 1'b0);
        tick_a("load_wrap", 8'd0, 8'd0, 1'b0, 1'b1);
`endif

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/cascaded_counter.md
# cascaded_counter

Parametrised chain of `STAGES` up-counters, each `WIDTH` bits wide, with per-stage runtime limits and two selectable cascade modes. Sequential mode fills stage 0 to its limit, then stage 1, and so on, and clears all stages one cycle after every stage reaches its limit. Odometer mode is a mixed-radix counter. The block is the general successor of the fixed two-stage 8/6 feedback counter, and serves as a sequencer or timebase generator inside pipelines.

## Interface
- `WIDTH`, 8: bits per stage.
- `STAGES`, 2: number of stages, ≥1.
- `clk_i`  in  1: clock; all state changes on its rising edge.
- `rst_i`  in  1: asynchronous, active-high reset.
- `en_i`  in  1: count enable; low holds all state.
- `clear_i`  in  1: synchronous clear of all stages; overrides `en_i`.
- `mode_i`  in  1: 0 = sequential, 1 = odometer.
- `limits_i`  in  STAGES*WIDTH: per-stage limit L_k; stage 0 in the most-significant WIDTH bits.
- `count_o`  out  STAGES*WIDTH: stage values, same packing as `limits_i` (stage 0 at MSBs).
- `done_o`  out  1: every stage value ≥ its limit (combinational from state).
- `wrap_o`  out  1: registered one-cycle pulse, high in the cycle after the chain cleared by wrap.
- `load_i`  in  1: present only with `CASCADED_COUNTER_LOAD_EN`.
- `load_value_i`  in  STAGES*WIDTH: present only with `CASCADED_COUNTER_LOAD_EN`.

## Operation
- Stage k is "full" when value_k ≥ L_k (unsigned). `>=` makes a lowered limit take effect at once. A stage with L_k = 0 is always full, so it is skipped.
- Priority per edge, highest first: `rst_i` (async), `clear_i`, `load_i` (if compiled), `en_i`, hold.
- **Sequential mode** (`mode_i` = 0), on an enabled cycle:
  - If all stages are full, every stage becomes 0 and `wrap_o` goes 1 next cycle.
  - Otherwise only the lowest-index non-full stage increments by 1. All others hold.
  - Period = ΣL_k + 1 enabled cycles.
- **Odometer mode** (`mode_i` = 1), on an enabled cycle:
  - Stage k steps when all stages j<k are full. Stage 0 always steps.
  - A stepping stage that is full becomes 0. Otherwise it increments.
  - When all stages are full and step, all become 0 and `wrap_o` pulses.
  - Period = Π(L_k+1).
- Increments never exceed 2^WIDTH−1. L_k = 2^WIDTH−1 is legal. No arithmetic overflow is possible because a full stage never increments.
- Switching `mode_i` mid-count is legal. The next step uses the new mode on the current values; no clear is implied.
- `clear_i` and `load_i` never assert `wrap_o`.

## Timing
- Reset values: `count_o` = 0, `wrap_o` = 0, `done_o` = (all L_k = 0).
- Latency is one cycle from an input sampled at edge n to `count_o` after edge n.
- `done_o` follows `count_o` and `limits_i` combinationally with zero latency.
- `wrap_o` is high exactly in the cycle whose `count_o` shows the post-wrap zeros.
- `rst_i` asserted mid-count zeroes all state immediately without waiting for a clock edge. Counting resumes on the first rising edge after deassertion.
- `en_i` low for any duration:
  - `count_o` is frozen.
  - `wrap_o` returns to 0 after one cycle.
  - Changes to `limits_i` made while disabled still affect `done_o`.

## Configuration
- `CASCADED_COUNTER_LOAD_EN` defined:
  - `load_i` and `load_value_i` exist.
  - When `load_i` = 1 and `clear_i` = 0, `count_o` ← `load_value_i` at the next edge, regardless of `en_i`.
  - Loaded values above a limit are kept as-is and count as full.
- Undefined:
  - The ports are absent.
  - The block has no load path.

## Test plan
- **Sequential baseline.** WIDTH=8, STAGES=2, limits {8,6}, `en_i`=1, release reset at a negedge.
  - Required at release: `count_o` = {0,0}.
  - Required after 8 negedges: {8,0}.
  - Required after 6 more: {8,6} with `done_o`=1.
  - Required after 1 more: {0,0} with `wrap_o`=1.
- **Odometer.** Limits {2,3}, mode 1.
  - Required sequence: {0,0},{1,0},{2,0},{0,1},…,{2,3}, then {0,0} with `wrap_o` after 12 steps.
- **Skipped stage.** STAGES=3, limits {2,0,1}, sequential mode.
  - Required sequence: {1,0,0},{2,0,0},{2,0,1},{0,0,0}, period 4.
- **Hold and clear.**
  - `en_i`=0 for 5 cycles at {3,0}: `count_o` stays {3,0}.
  - `clear_i`=1 together with `en_i`=1: {0,0}, and `wrap_o` stays 0.
- **Async reset and limit change.**
  - `rst_i` pulsed between edges at {8,4}: `count_o` is {0,0} before the next edge.
  - L_0 lowered from 8 to 3 while stage 0 = 5: stage 0 is treated as full, and stage 1 steps next cycle.
- **Load, with `CASCADED_COUNTER_LOAD_EN`.** `load_value_i` = {7,5}, limits {8,6}.
  - Required sequence: {7,5}, then {8,5}, {8,6}, then {0,0} with `wrap_o`=1.
